// File: rtl/reading_filter.sv
// reading_filter: moving-average filter between the AD7705 capture FSM and seg_driver.
// Resynchronises the raw ADC code, averages DEPTH accepted samples, scales the result to
// millivolts and adds display hold, peak hold and over-range flagging.
module reading_filter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LOG2_D   = 2,
    parameter int unsigned OVR_CODE = 65000
) (
    input  logic        clk_4hz,
    input  logic        reset,
    input  logic [15:0] raw_code,
    input  logic        hold_n,
    input  logic        peak_mode,
    output logic [15:0] mv,
    output logic        disp_strobe,
    output logic        over_range,
    output logic        primed
);

    localparam int unsigned SW = 16 + LOG2_D;
    localparam int unsigned CW = LOG2_D + 1;

    typedef enum logic [1:0] {StFill, StRun, StHold} state_e;

    state_e              state_q, state_d;
    logic [15:0]         s1_q, s1_d;
    logic [15:0]         s2_q, s2_d;
    logic [15:0]         ring_q [DEPTH];
    logic [15:0]         ring_d [DEPTH];
    logic [SW-1:0]       sum_q, sum_d;
    logic [LOG2_D-1:0]   wp_q, wp_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         peak_q, peak_d;
    logic                pm_q, pm_d;
    logic [15:0]         mv_q, mv_d;
    logic                strobe_q, strobe_d;
    logic                ovr_q, ovr_d;
    logic                primed_q, primed_d;

    logic                accept;
    logic [LOG2_D-1:0]   wp_prev;
    logic [15:0]         newest;
    logic [15:0]         avg;
    logic [15:0]         src;
    logic [25:0]         prod;
    logic [25:0]         quo;
    logic [15:0]         calc;
    logic [15:0]         peak_base;
    logic [15:0]         mv_next;

    // CDC pipe, ring buffer update and the value fed to the mV scaler
    always_comb begin
        s1_d    = raw_code;
        s2_d    = s1_q;
        ring_d  = ring_q;
        sum_d   = sum_q;
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        accept  = (s1_q == s2_q);
        wp_prev = wp_q - 1'b1;
        // On a skipped tick during FILL the newest accepted sample is the last one written
        newest  = ring_q[wp_prev];
        if (accept) begin
            sum_d        = sum_q - SW'(ring_q[wp_q]) + SW'(s2_q);
            ring_d[wp_q] = s2_q;
            wp_d         = wp_q + 1'b1;
            newest       = s2_q;
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        avg  = sum_d[SW-1:LOG2_D];
        src  = (state_q == StFill) ? newest : avg;
        prod = 26'(src) * 26'd1000;
        quo  = prod / 26'd13107;
        // Full scale divides out to exactly 5000; clamp so the display stays within 0..4999
        calc = (quo > 26'd4999) ? 16'd4999 : quo[15:0];
    end

    // Peak hold, display hold, strobe, over-range and state transitions
    always_comb begin
        pm_d      = peak_mode;
        peak_base = (peak_mode && !pm_q) ? 16'd0 : peak_q;
        mv_next   = (peak_mode && (peak_base > calc)) ? peak_base : calc;
        peak_d    = peak_mode ? mv_next : peak_q;
        mv_d      = (state_q == StHold) ? mv_q : mv_next;
        strobe_d  = (mv_d != mv_q);
        ovr_d     = (src >= 16'(OVR_CODE));
        state_d   = state_q;
        primed_d  = primed_q;
        case (state_q)
            StFill: begin
                if (accept && (cnt_d == CW'(DEPTH))) begin
                    primed_d = 1'b1;
                    state_d  = hold_n ? StRun : StHold;
                end
            end
            StRun: begin
                if (!hold_n) state_d = StHold;
            end
            StHold: begin
                if (hold_n) state_d = StRun;
            end
            default: state_d = StFill;
        endcase
    end

    // All state and registered outputs; reset clears everything immediately
    always_ff @(posedge clk_4hz or negedge reset) begin
        if (!reset) begin
            state_q  <= StFill;
            s1_q     <= '0;
            s2_q     <= '0;
            ring_q   <= '{default: '0};
            sum_q    <= '0;
            wp_q     <= '0;
            cnt_q    <= '0;
            peak_q   <= '0;
            pm_q     <= 1'b0;
            mv_q     <= '0;
            strobe_q <= 1'b0;
            ovr_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            ring_q   <= ring_d;
            sum_q    <= sum_d;
            wp_q     <= wp_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            pm_q     <= pm_d;
            mv_q     <= mv_d;
            strobe_q <= strobe_d;
            ovr_q    <= ovr_d;
            primed_q <= primed_d;
        end
    end

    assign mv          = mv_q;
    assign disp_strobe = strobe_q;
    assign over_range  = ovr_q;
    assign primed      = primed_q;

endmodule

// File: tb/tb_reading_filter.sv
// Bench for reading_filter: directed scenarios plus randomized traffic, all checked
// every cycle against a sample-window model of the filter.
module tb_reading_filter;

    localparam int unsigned Depth = 4;

    logic        clk_4hz;
    logic        reset;
    logic [15:0] raw_code;
    logic        hold_n;
    logic        peak_mode;
    logic [15:0] mv;
    logic        disp_strobe;
    logic        over_range;
    logic        primed;

    reading_filter #(
        .DEPTH    (4),
        .LOG2_D   (2),
        .OVR_CODE (65000)
    ) dut (
        .clk_4hz     (clk_4hz),
        .reset       (reset),
        .raw_code    (raw_code),
        .hold_n      (hold_n),
        .peak_mode   (peak_mode),
        .mv          (mv),
        .disp_strobe (disp_strobe),
        .over_range  (over_range),
        .primed      (primed)
    );

    initial clk_4hz = 1'b0;
    always #5 clk_4hz = ~clk_4hz;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          chk_en   = 1'b0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_win[$];
    int unsigned m_s1, m_s2, m_newest, m_nacc, m_peak;
    bit          m_pm;
    int          m_phase;   // 0 filling, 1 running, 2 held
    int unsigned exp_mv;
    bit          exp_strobe, exp_ovr, exp_primed;

    function automatic int unsigned to_mv(input int unsigned code);
        int unsigned q;
        q = code * 1000 / 13107;
        return (q > 4999) ? 4999 : q;
    endfunction

    task automatic model_reset();
        m_win.delete();
        m_s1 = 0; m_s2 = 0; m_newest = 0; m_nacc = 0; m_peak = 0; m_pm = 0; m_phase = 0;
        exp_mv = 0; exp_strobe = 0; exp_ovr = 0; exp_primed = 0;
    endtask

    task automatic model_step();
        int unsigned sum, src, calc, pk, mvn;
        if (m_s1 == m_s2) begin
            m_win.push_back(m_s2);
            if (m_win.size() > Depth) m_win.delete(0);
            m_newest = m_s2;
            m_nacc++;
        end
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        src  = (m_phase == 0) ? m_newest : sum / Depth;
        calc = to_mv(src);
        pk   = (peak_mode && !m_pm) ? 0 : m_peak;
        mvn  = (peak_mode && pk > calc) ? pk : calc;
        if (peak_mode) m_peak = mvn;
        if (m_phase != 2) begin
            exp_strobe = (mvn != exp_mv);
            exp_mv     = mvn;
        end else begin
            exp_strobe = 1'b0;
        end
        exp_ovr = (src >= 65000);
        case (m_phase)
            0: if (m_nacc >= Depth) begin
                exp_primed = 1'b1;
                m_phase    = hold_n ? 1 : 2;
            end
            1: if (!hold_n) m_phase = 2;
            default: if (hold_n) m_phase = 1;
        endcase
        m_pm = peak_mode;
        m_s2 = m_s1;
        m_s1 = raw_code;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_4hz or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare, away from the active edge
    initial begin
        forever begin
            @(negedge clk_4hz);
            if (chk_en) begin
                chk("mv", mv, exp_mv);
                chk("disp_strobe", disp_strobe, exp_strobe);
                chk("over_range", over_range, exp_ovr);
                chk("primed", primed, exp_primed);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int unsigned r, input bit h, input bit p);
        @(negedge clk_4hz);
        raw_code  = 16'(r);
        hold_n    = h;
        peak_mode = p;
    endtask

    task automatic run(input int unsigned n, input int unsigned r, input bit h, input bit p);
        for (int i = 0; i < int'(n); i++) drive(r, h, p);
        @(negedge clk_4hz);
    endtask

    int unsigned rv;
    bit          rh, rp;

    initial begin
        reset = 1'b0; raw_code = '0; hold_n = 1'b1; peak_mode = 1'b0;
        #23;
        chk("reset mv", mv, 0);
        chk("reset primed", primed, 0);
        chk("reset strobe", disp_strobe, 0);
        reset = 1'b1;
        chk_en = 1'b1;

        // Steady 13107: fill then prime at 1000 mV
        drive(13107, 1, 0);
        drive(13107, 1, 0);
        @(negedge clk_4hz);
        chk("fill not primed", primed, 0);
        run(8, 13107, 1, 0);
        chk("s1 mv", mv, 1000);
        chk("s1 primed", primed, 1);

        // Step to full scale
        run(10, 65535, 1, 0);
        chk("s2 mv", mv, 4999);
        chk("s2 over_range", over_range, 1);

        // Hold at 2000 mV while the input drops to zero
        run(10, 26214, 1, 0);
        chk("s4 pre mv", mv, 2000);
        run(8, 0, 0, 0);
        chk("s4 held mv", mv, 2000);
        chk("s4 held strobe", disp_strobe, 0);
        run(6, 0, 1, 0);
        chk("s4 released mv", mv, 0);

        // Peak hold: ramp 1000 -> 3000, fall to 500
        run(8, 13107, 1, 0);
        run(8, 13107, 1, 1);
        run(8, 26214, 1, 1);
        run(8, 39321, 1, 1);
        run(8, 6554, 1, 1);
        chk("s5 peak mv", mv, 3000);
        run(3, 6554, 1, 0);
        chk("s5 off mv", mv, 500);
        run(3, 6554, 1, 1);
        chk("s5 rise mv", mv, 500);

        // Alternating input: every tick after the first is skipped
        for (int i = 0; i < 6; i++) drive((i % 2 == 0) ? 1000 : 2000, 1, 1);
        @(negedge clk_4hz);
        chk("s3 mv", mv, 500);
        chk("s3 strobe", disp_strobe, 0);

        // Asynchronous reset mid-run
        @(posedge clk_4hz);
        #2 reset = 1'b0;
        #1;
        chk("s6 mv", mv, 0);
        chk("s6 primed", primed, 0);
        chk("s6 over_range", over_range, 0);
        @(negedge clk_4hz);
        reset = 1'b1;
        run(2, 26214, 1, 0);
        chk("s6 refill primed", primed, 0);

        // Randomized traffic
        rv = 13107; rh = 1'b1; rp = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: rv = $urandom_range(0, 65535);
                    1: rv = $urandom_range(64900, 65535);
                    2: rv = $urandom_range(0, 2000);
                    default: rv = rv ^ 16'h0001;
                endcase
            end
            if ($urandom_range(0, 9) == 0) rh = ~rh;
            if ($urandom_range(0, 11) == 0) rp = ~rp;
            drive(rv, rh, rp);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end
        @(negedge clk_4hz);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
